// File: rtl/regfile_onehot_wb_if.sv
// regfile_onehot_wb_if
//   Bus bundle for the 16-entry write-back register bank.
//   master : write-back source / operand reader (drives writes, busy marks, read indices, err_clr)
//   slave  : the register bank (drives read data, stalls, scoreboard, error flag, write count)
//   Signals:
//     wr_valid, wr_en_onehot[15:0], wr_data[DATA_W-1:0] : write-back strobe, decoder select, data
//     busy_set_onehot[15:0]                             : mark a register as having a pending result
//     rd_addr_a/b[3:0], rd_data_a/b, stall_a/b          : two combinational read ports
//     busy[15:0], err_clr, err_multi_hot, wr_count[7:0] : scoreboard, sticky error, write counter
interface regfile_onehot_wb_if #(
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic [15:0]       wr_en_onehot;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       busy_set_onehot;
    logic [3:0]        rd_addr_a;
    logic [3:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              stall_a;
    logic              stall_b;
    logic [15:0]       busy;
    logic              err_clr;
    logic              err_multi_hot;
    logic [7:0]        wr_count;

    modport master (
        output wr_valid, wr_en_onehot, wr_data, busy_set_onehot,
               rd_addr_a, rd_addr_b, err_clr,
        input  rd_data_a, rd_data_b, stall_a, stall_b, busy,
               err_multi_hot, wr_count
    );

    modport slave (
        input  wr_valid, wr_en_onehot, wr_data, busy_set_onehot,
               rd_addr_a, rd_addr_b, err_clr,
        output rd_data_a, rd_data_b, stall_a, stall_b, busy,
               err_multi_hot, wr_count
    );
endinterface

// File: rtl/regfile_onehot_wb.sv
// regfile_onehot_wb
//   16-entry register bank fed by the 4-to-16 destination decoder. Writes are
//   selected by a one-hot enable word; a second one-hot word marks registers
//   whose result is still in flight. Two combinational read ports bypass the
//   current write and raise a stall while their register is marked busy.
//   Multi-hot enable or busy-set words are dropped and raise a sticky error.
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset
//     bus : regfile_onehot_wb_if.slave (write-back, busy marks, read ports, status)
//   Optional build macro REGFILE_R0_ZERO_EN: register 0 is hard-wired to zero
//   (reads 0, never busy, writes discarded but still counted).
module regfile_onehot_wb #(
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input logic                clk,
    input logic                rst,
    regfile_onehot_wb_if.slave bus
);

    logic [DATA_W-1:0] regs [16];
    logic [15:0]       busy_q;
    logic [15:0]       busy_d;
    logic [15:0]       wr_sel;
    logic [15:0]       wr_store;
    logic [15:0]       set_sel;
    logic              wr_legal;
    logic              wr_multi;
    logic              set_legal;
    logic              set_multi;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic              hit_a;
    logic              hit_b;

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    function automatic logic is_multihot(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'h0000;
    endfunction

    always_comb begin
        wr_legal  = bus.wr_valid && is_onehot(bus.wr_en_onehot);
        wr_multi  = bus.wr_valid && is_multihot(bus.wr_en_onehot);
        set_legal = is_onehot(bus.busy_set_onehot);
        set_multi = is_multihot(bus.busy_set_onehot);
        wr_sel    = wr_legal  ? bus.wr_en_onehot    : 16'h0000;
        set_sel   = set_legal ? bus.busy_set_onehot : 16'h0000;
        wr_store  = wr_sel;
`ifdef REGFILE_R0_ZERO_EN
        // Legality is judged on the raw words so a multi-hot word touching bit 0
        // still flags an error; only the effect on register 0 is masked.
        wr_store[0] = 1'b0;
        set_sel[0]  = 1'b0;
`endif
        // Set is OR-ed in after the clear so a same-cycle re-issue keeps the bit.
        busy_d = (busy_q & ~wr_sel) | set_sel;
    end

    always_comb begin
        hit_a         = wr_sel[bus.rd_addr_a];
        hit_b         = wr_sel[bus.rd_addr_b];
        bus.rd_data_a = hit_a ? bus.wr_data : regs[bus.rd_addr_a];
        bus.rd_data_b = hit_b ? bus.wr_data : regs[bus.rd_addr_b];
        bus.stall_a   = busy_q[bus.rd_addr_a] & ~hit_a;
        bus.stall_b   = busy_q[bus.rd_addr_b] & ~hit_b;
`ifdef REGFILE_R0_ZERO_EN
        if (bus.rd_addr_a == 4'd0) begin
            bus.rd_data_a = '0;
            bus.stall_a   = 1'b0;
        end
        if (bus.rd_addr_b == 4'd0) begin
            bus.rd_data_b = '0;
            bus.stall_b   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= RST_VAL;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_store[i]) begin
                    regs[i] <= bus.wr_data;
                end
            end
            busy_q <= busy_d;
            if (wr_multi || set_multi) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            if (wr_legal) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.err_multi_hot = err_q;
    assign bus.wr_count      = cnt_q;

endmodule
